// File: rtl/fp_unpack_pipe.sv
// fp_unpack_pipe
// Two-stage pipelined IEEE-754 unpacker with valid/ready on both sides.
// Stage 1 registers the raw fields (sign, exponent field, mantissa) and
// the one-hot class. Stage 2 computes the unbiased exponent and the
// significand with explicit leading bit. With NORM=1 it also left-normalizes
// subnormals. Stage 2 registers drive the outputs directly.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (flushes both stages)
//   in_valid   in_f holds an operand
//   in_ready   operand accepted this cycle (combinational from out_ready)
//   in_f       packed operand {sign, exponent field, mantissa}
//   out_valid  output fields valid
//   out_ready  consumer takes the output this cycle
//   out_sign   sign bit
//   out_exp    signed unbiased exponent, NEXP+2 bits
//   out_sig    significand with explicit leading bit at the MSB
//   out_flags  one-hot class {SNAN, QNAN, INF, ZERO, SUBNORMAL, NORMAL}

module fp_unpack_pipe #(
   parameter int NEXP = 5,
   parameter int NSIG = 10,
   parameter int NORM = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NEXP+NSIG:0]     in_f,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_sign,
   output logic signed [NEXP+1:0] out_exp,
   output logic [NSIG:0]          out_sig,
   output logic [5:0]             out_flags
);

   localparam int EW   = NEXP + 2;
   localparam int LZW  = $clog2(NSIG + 2);
   localparam int BIAS = (2 ** (NEXP - 1)) - 1;

   localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
   localparam logic signed [EW-1:0] EMIN_E = EW'(1 - BIAS);
   localparam logic signed [EW-1:0] EINF_E = EW'(BIAS + 1);
   localparam logic [LZW-1:0]       LZ_ONE = LZW'(1);

   localparam logic [NEXP-1:0] EXP_ONES = {NEXP{1'b1}};
   localparam logic [NEXP-1:0] EXP_ZERO = {NEXP{1'b0}};
   localparam logic [NSIG-1:0] MAN_ZERO = {NSIG{1'b0}};

   localparam logic [5:0] C_NORMAL = 6'b000001;
   localparam logic [5:0] C_SUB    = 6'b000010;
   localparam logic [5:0] C_ZERO   = 6'b000100;
   localparam logic [5:0] C_INF    = 6'b001000;
   localparam logic [5:0] C_QNAN   = 6'b010000;
   localparam logic [5:0] C_SNAN   = 6'b100000;

   // Leading zeros of v scanned from the MSB. The caller passes {0, m}
   // with m nonzero, so the result lies in 1..NSIG.
   function automatic logic [LZW-1:0] lead_zeros(input logic [NSIG:0] v);
      logic [LZW-1:0] cnt;
      logic           hit;
      cnt = {LZW{1'b0}};
      hit = 1'b0;
      for (int i = NSIG; i >= 0; i--) begin
         if (hit || v[i]) begin
            hit = 1'b1;
         end else begin
            cnt = cnt + LZ_ONE;
         end
      end
      return cnt;
   endfunction

   // ---------------- stage 1 ----------------
   logic                 in_sign_s;
   logic [NEXP-1:0]      in_exp_s;
   logic [NSIG-1:0]      in_man_s;
   logic [5:0]           in_class_s;

   logic                 s1_valid_r;
   logic                 s1_sign_r;
   logic [NEXP-1:0]      s1_exp_r;
   logic [NSIG-1:0]      s1_man_r;
   logic [5:0]           s1_class_r;

   logic                 s1_adv_s;
   logic                 s2_adv_s;

   // ---------------- stage 2 ----------------
   logic                 s2_valid_r;
   logic                 out_sign_r;
   logic signed [EW-1:0] out_exp_r;
   logic [NSIG:0]        out_sig_r;
   logic [5:0]           out_flags_r;

   logic [LZW-1:0]       lz_s;
   logic [EW-1:0]        lz_ext_s;
   logic [NSIG:0]        sub_sig_s;
   logic signed [EW-1:0] nxt_exp_s;
   logic [NSIG:0]        nxt_sig_s;

   assign in_sign_s = in_f[NEXP+NSIG];
   assign in_exp_s  = in_f[NEXP+NSIG-1:NSIG];
   assign in_man_s  = in_f[NSIG-1:0];

   // Stage 2 moves when it is empty or its content is being taken; stage 1
   // moves when it is empty or stage 2 moves. in_ready is therefore a pure
   // function of the pipe state and out_ready, never of in_valid.
   assign s2_adv_s = ~s2_valid_r | out_ready;
   assign s1_adv_s = ~s1_valid_r | s2_adv_s;
   assign in_ready = s1_adv_s;

   // Classify the incoming operand from its exponent and mantissa fields.
   always_comb begin
      in_class_s = C_NORMAL;
      if (in_exp_s == EXP_ONES) begin
         if (in_man_s == MAN_ZERO) begin
            in_class_s = C_INF;
         end else if (in_man_s[NSIG-1]) begin
            in_class_s = C_QNAN;
         end else begin
            in_class_s = C_SNAN;
         end
      end else if (in_exp_s == EXP_ZERO) begin
         if (in_man_s == MAN_ZERO) begin
            in_class_s = C_ZERO;
         end else begin
            in_class_s = C_SUB;
         end
      end else begin
         in_class_s = C_NORMAL;
      end
   end

   // Stage 1 register: captures raw fields and class on an input transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_sign_r  <= 1'b0;
         s1_exp_r   <= EXP_ZERO;
         s1_man_r   <= MAN_ZERO;
         s1_class_r <= 6'b000000;
      end else if (s1_adv_s) begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_sign_r  <= in_sign_s;
            s1_exp_r   <= in_exp_s;
            s1_man_r   <= in_man_s;
            s1_class_r <= in_class_s;
         end
      end
   end

   // Normalization shift for subnormals: after the shift the MSB is 1.
   assign lz_s      = lead_zeros({1'b0, s1_man_r});
   assign lz_ext_s  = EW'(lz_s);
   assign sub_sig_s = {1'b0, s1_man_r} << lz_s;

   // Exponent and significand per class.
   always_comb begin
      nxt_exp_s = {EW{1'b0}};
      nxt_sig_s = {(NSIG+1){1'b0}};
      case (s1_class_r)
         C_NORMAL: begin
            nxt_exp_s = $signed({2'b00, s1_exp_r}) - BIAS_E;
            nxt_sig_s = {1'b1, s1_man_r};
         end
         C_SUB: begin
            if (NORM != 0) begin
               nxt_exp_s = EMIN_E - $signed(lz_ext_s);
               nxt_sig_s = sub_sig_s;
            end else begin
               nxt_exp_s = EMIN_E;
               nxt_sig_s = {1'b0, s1_man_r};
            end
         end
         C_ZERO: begin
            nxt_exp_s = {EW{1'b0}};
            nxt_sig_s = {(NSIG+1){1'b0}};
         end
         // NaN payloads pass through untouched; signalling NaNs are not quieted.
         C_INF, C_QNAN, C_SNAN: begin
            nxt_exp_s = EINF_E;
            nxt_sig_s = {1'b0, s1_man_r};
         end
         default: begin
            nxt_exp_s = {EW{1'b0}};
            nxt_sig_s = {(NSIG+1){1'b0}};
         end
      endcase
   end

   // Stage 2 register: output data loads only when a real operand moves in,
   // so bubbles never disturb the visible fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_r  <= 1'b0;
         out_sign_r  <= 1'b0;
         out_exp_r   <= {EW{1'b0}};
         out_sig_r   <= {(NSIG+1){1'b0}};
         out_flags_r <= 6'b000000;
      end else if (s2_adv_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            out_sign_r  <= s1_sign_r;
            out_exp_r   <= nxt_exp_s;
            out_sig_r   <= nxt_sig_s;
            out_flags_r <= s1_class_r;
         end
      end
   end

   assign out_valid = s2_valid_r;
   assign out_sign  = out_sign_r;
   assign out_exp   = out_exp_r;
   assign out_sig   = out_sig_r;
   assign out_flags = out_flags_r;

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Testbench for fp_unpack_pipe. Three instances: half precision with
// normalization (0), half precision without normalization (1), single
// precision with normalization (2). A negedge monitor pushes reference
// results on input transfers and pops/compares on output transfers.

module tb_fp_unpack_pipe;

   typedef struct packed {
      logic               s;
      logic signed [31:0] e;
      logic [23:0]        sig;
      logic [5:0]         fl;
   } res_t;

   localparam logic [5:0] FL_NORMAL = 6'b000001;
   localparam logic [5:0] FL_SUB    = 6'b000010;
   localparam logic [5:0] FL_ZERO   = 6'b000100;
   localparam logic [5:0] FL_INF    = 6'b001000;
   localparam logic [5:0] FL_QNAN   = 6'b010000;
   localparam logic [5:0] FL_SNAN   = 6'b100000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic               in_valid_a  [3];
   logic [31:0]        in_f_a      [3];
   logic               out_ready_a [3];
   logic               in_ready_w  [3];
   logic               out_valid_w [3];
   logic               out_sign_w  [3];
   logic signed [31:0] out_exp_w   [3];
   logic [23:0]        out_sig_w   [3];
   logic [5:0]         out_flags_w [3];

   logic signed [6:0] exp0, exp1;
   logic signed [9:0] exp2;
   logic [10:0]       sig0, sig1;
   logic [23:0]       sig2;

   assign out_exp_w[0] = 32'(exp0);
   assign out_exp_w[1] = 32'(exp1);
   assign out_exp_w[2] = 32'(exp2);
   assign out_sig_w[0] = 24'(sig0);
   assign out_sig_w[1] = 24'(sig1);
   assign out_sig_w[2] = sig2;

   fp_unpack_pipe #(.NEXP(5), .NSIG(10), .NORM(1)) dut0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_a[0]), .in_ready(in_ready_w[0]), .in_f(in_f_a[0][15:0]),
      .out_valid(out_valid_w[0]), .out_ready(out_ready_a[0]),
      .out_sign(out_sign_w[0]), .out_exp(exp0), .out_sig(sig0), .out_flags(out_flags_w[0]));

   fp_unpack_pipe #(.NEXP(5), .NSIG(10), .NORM(0)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_a[1]), .in_ready(in_ready_w[1]), .in_f(in_f_a[1][15:0]),
      .out_valid(out_valid_w[1]), .out_ready(out_ready_a[1]),
      .out_sign(out_sign_w[1]), .out_exp(exp1), .out_sig(sig1), .out_flags(out_flags_w[1]));

   fp_unpack_pipe #(.NEXP(8), .NSIG(23), .NORM(1)) dut2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_a[2]), .in_ready(in_ready_w[2]), .in_f(in_f_a[2]),
      .out_valid(out_valid_w[2]), .out_ready(out_ready_a[2]),
      .out_sign(out_sign_w[2]), .out_exp(exp2), .out_sig(sig2), .out_flags(out_flags_w[2]));

   int checks = 0;
   int errors = 0;

   function automatic int cfg_nexp(input int k);
      return (k == 2) ? 8 : 5;
   endfunction

   function automatic int cfg_nsig(input int k);
      return (k == 2) ? 23 : 10;
   endfunction

   function automatic bit cfg_norm(input int k);
      return (k != 1);
   endfunction

   function automatic string fmt(input res_t v);
      return $sformatf("sign=%0d exp=%0d sig=0x%0h flags=%b", v.s, $signed(v.e), v.sig, v.fl);
   endfunction

   task automatic check(input string name, input bit ok, input string act, input string req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %s, expected %s", name, act, req);
      end
   endtask

   // Reference: decode the word with integer arithmetic.
   function automatic res_t ref_model(input int k, input logic [31:0] f);
      int     nexp, nsig, ex;
      longint one, fv, bias, e, m, sig;
      res_t   r;
      nexp = cfg_nexp(k);
      nsig = cfg_nsig(k);
      one  = 1;
      fv   = longint'(f);
      bias = (one << (nexp - 1)) - 1;
      e    = (fv >> nsig) & ((one << nexp) - 1);
      m    = fv & ((one << nsig) - 1);
      r.s  = f[nexp + nsig];
      if (e == (one << nexp) - 1) begin
         ex  = int'(bias + 1);
         sig = m;
         if (m == 0) r.fl = FL_INF;
         else if (((m >> (nsig - 1)) & 1) == 1) r.fl = FL_QNAN;
         else r.fl = FL_SNAN;
      end else if (e == 0) begin
         if (m == 0) begin
            ex = 0; sig = 0; r.fl = FL_ZERO;
         end else begin
            ex = int'(1 - bias); sig = m; r.fl = FL_SUB;
            if (cfg_norm(k)) begin
               while (sig < (one << nsig)) begin
                  sig = sig * 2;
                  ex  = ex - 1;
               end
            end
         end
      end else begin
         ex   = int'(e - bias);
         sig  = m + (one << nsig);
         r.fl = FL_NORMAL;
      end
      r.e   = 32'(ex);
      r.sig = 24'(sig);
      return r;
   endfunction

   function automatic logic [31:0] gen_op(input int k);
      int          nexp, nsig, cat;
      logic [31:0] emask, mmask, s, e, m;
      nexp  = cfg_nexp(k);
      nsig  = cfg_nsig(k);
      emask = (32'd1 << nexp) - 32'd1;
      mmask = (32'd1 << nsig) - 32'd1;
      cat   = int'($urandom_range(0, 5));
      s     = 32'($urandom_range(0, 1));
      case (cat)
         0: begin e = 32'd0; m = 32'd1 << $urandom_range(0, nsig - 1); end
         1: begin e = 32'd0; m = ($urandom_range(0, 1) == 1) ? ($urandom & mmask) : 32'd0; end
         2: begin
            e = emask;
            case ($urandom_range(0, 2))
               0: m = 32'd0;
               1: m = (32'd1 << (nsig - 1)) | ($urandom & mmask);
               default: m = ($urandom & (mmask >> 1)) | 32'd1;
            endcase
         end
         default: begin e = 32'($urandom_range(1, 32'(emask - 32'd1))); m = $urandom & mmask; end
      endcase
      return (s << (nexp + nsig)) | (e << nsig) | m;
   endfunction

   function automatic res_t cur(input int k);
      res_t v;
      v.s   = out_sign_w[k];
      v.e   = out_exp_w[k];
      v.sig = out_sig_w[k];
      v.fl  = out_flags_w[k];
      return v;
   endfunction

   // ---------------- scoreboard monitor ----------------
   res_t sbq [3][$];
   logic acc_last  [3] = '{default: 1'b0};
   logic stall_prev[3] = '{default: 1'b0};
   res_t snap      [3] = '{default: '0};
   logic rst_prev = 1'b0;

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         res_t got, want;
         bit   rdy_exp;
         got = cur(k);
         if (rst_prev) begin
            check($sformatf("reset_state[%0d]", k),
                  !out_valid_w[k] && got == '0 && in_ready_w[k],
                  $sformatf("valid=%0d ready=%0d %s", out_valid_w[k], in_ready_w[k], fmt(got)),
                  "valid=0 ready=1 all fields 0");
         end
         if (stall_prev[k]) begin
            check($sformatf("stall_hold[%0d]", k), out_valid_w[k] && got == snap[k],
                  $sformatf("valid=%0d %s", out_valid_w[k], fmt(got)),
                  $sformatf("valid=1 %s", fmt(snap[k])));
         end
         rdy_exp = (sbq[k].size() < 2) || out_ready_a[k];
         check($sformatf("in_ready[%0d]", k), in_ready_w[k] == rdy_exp,
               $sformatf("%0d", in_ready_w[k]), $sformatf("%0d", rdy_exp));
         if (rst) begin
            sbq[k].delete();
            acc_last[k] <= 1'b0;
         end else begin
            if (out_valid_w[k] && out_ready_a[k]) begin
               if (sbq[k].size() == 0) begin
                  check($sformatf("unexpected_out[%0d]", k), 1'b0, fmt(got), "no output");
               end else begin
                  want = sbq[k].pop_front();
                  check($sformatf("data[%0d]", k), got == want, fmt(got), fmt(want));
               end
            end
            if (in_valid_a[k] && in_ready_w[k]) begin
               sbq[k].push_back(ref_model(k, in_f_a[k]));
            end
            acc_last[k] <= in_valid_a[k] && in_ready_w[k];
         end
         stall_prev[k] <= out_valid_w[k] && !out_ready_a[k] && !rst;
         snap[k]       <= got;
      end
      rst_prev <= rst;
   end

   // One operand through an empty pipe, with fixed expected fields and latency.
   task automatic directed(input string name, input int k, input logic [31:0] f,
                           input logic xs, input int xe, input logic [23:0] xsig,
                           input logic [5:0] xfl);
      res_t xv;
      xv.s = xs; xv.e = 32'(xe); xv.sig = xsig; xv.fl = xfl;
      @(posedge clk); #1;
      in_valid_a[k] = 1'b1; in_f_a[k] = f; out_ready_a[k] = 1'b1;
      @(posedge clk); #1;
      in_valid_a[k] = 1'b0;
      @(negedge clk);
      check({name, "_early"}, !out_valid_w[k], $sformatf("valid=%0d", out_valid_w[k]), "valid=0");
      @(negedge clk);
      check(name, out_valid_w[k] && cur(k) == xv,
            $sformatf("valid=%0d %s", out_valid_w[k], fmt(cur(k))), $sformatf("valid=1 %s", fmt(xv)));
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid_a[k] = 1'b0; in_f_a[k] = 32'd0; out_ready_a[k] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      directed("h_one",      0, 32'h3C00, 1'b0,    0, 24'h400,    FL_NORMAL);
      directed("h_neg",      0, 32'hC500, 1'b1,    2, 24'h500,    FL_NORMAL);
      directed("h_sub_min",  0, 32'h0001, 1'b0,  -24, 24'h400,    FL_SUB);
      directed("h_sub_raw",  1, 32'h0001, 1'b0,  -14, 24'h001,    FL_SUB);
      directed("h_sub_max",  0, 32'h03FF, 1'b0,  -15, 24'h7FE,    FL_SUB);
      directed("h_inf",      0, 32'h7C00, 1'b0,   16, 24'h000,    FL_INF);
      directed("h_qnan",     0, 32'h7E00, 1'b0,   16, 24'h200,    FL_QNAN);
      directed("h_snan",     0, 32'h7D00, 1'b0,   16, 24'h100,    FL_SNAN);
      directed("h_negzero",  0, 32'h8000, 1'b1,    0, 24'h000,    FL_ZERO);
      directed("h_maxnorm",  1, 32'hFBFF, 1'b1,   15, 24'h7FF,    FL_NORMAL);
      directed("s_sub_min",  2, 32'h00000001, 1'b0, -149, 24'h800000, FL_SUB);
      directed("s_inf",      2, 32'h7F800000, 1'b0,  128, 24'h000000, FL_INF);

      // Fill both stages under backpressure, then reset with an operand offered.
      @(posedge clk); #1;
      in_valid_a[0] = 1'b1; in_f_a[0] = 32'h4000; out_ready_a[0] = 1'b0;
      @(posedge clk); #1;
      in_f_a[0] = 32'h4400;
      @(posedge clk); #1;
      in_f_a[0] = 32'h4800;
      @(negedge clk);
      check("full_stall_ready", !in_ready_w[0], $sformatf("%0d", in_ready_w[0]), "0");
      @(posedge clk); #1;
      rst = 1'b1; out_ready_a[0] = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid_a[0] = 1'b0;
      @(negedge clk);
      check("rst_flush", !out_valid_w[0] && in_ready_w[0] && cur(0) == '0,
            $sformatf("valid=%0d ready=%0d %s", out_valid_w[0], in_ready_w[0], fmt(cur(0))),
            "valid=0 ready=1 all fields 0");
      directed("h_after_rst", 0, 32'h3C00, 1'b0, 0, 24'h400, FL_NORMAL);

      // Random traffic with random backpressure and rare resets.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         rst = ($urandom_range(0, 199) == 0);
         for (int k = 0; k < 3; k++) begin
            if (!in_valid_a[k] || acc_last[k]) begin
               in_valid_a[k] = ($urandom_range(0, 3) != 0);
               in_f_a[k]     = gen_op(k);
            end
            out_ready_a[k] = ($urandom_range(0, 2) != 0);
         end
      end

      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid_a[k] = 1'b0; out_ready_a[k] = 1'b1;
      end
      repeat (6) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("drain[%0d]", k), sbq[k].size() == 0,
               $sformatf("%0d pending", sbq[k].size()), "0 pending");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
